key_event_arbiter: RTL and testbench
====================================

# key_event_arbiter

Converts the DE2i-150 pushbuttons into clean, one-per-transfer key events for the VGA control logic (mode select, cursor move, colour step). Each key is synchronised, debounced, press-edge detected and optionally auto-repeated while held. A round-robin arbiter then serialises the per-key events onto a single valid/ready event port. It sits between the raw KEY pins and the VGA command decoder, replacing free-running per-key edge detectors.

## Interface
- NKEYS, 4: number of keys (2..8)
- DEB_CYCLES, 500000: consecutive stable samples to accept a level change (10 ms at 50 MHz); minimum 2
- REP_DELAY, 25000000: cycles from accepted press to first repeat event
- REP_PERIOD, 5000000: cycles between subsequent repeat events
- KEY_ACTIVE_LOW, 1: 1 = raw key reads 0 when pressed

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_in  in  NKEYS  raw asynchronous key pins
- repeat_en  in  NKEYS  per-key auto-repeat enable, sampled every cycle
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event when high with evt_valid
- evt_id  out  clog2(NKEYS)  key index of the event
- evt_repeat  out  1  0 = initial press, 1 = auto-repeat
- key_state  out  NKEYS  debounced levels, 1 = pressed
- evt_drop  out  1  sticky: an event was lost; cleared only by rst

## Operation
- Sync: key_in normalised to pressed=1 (inverted if KEY_ACTIVE_LOW), then 2-FF synchroniser per key; synchroniser reset value 0.
- Debounce per key: counter increments each cycle the synced value differs from key_state, clears when equal; at count DEB_CYCLES-1 with values still different, key_state toggles and counter clears.
- Per-key repeat FSM: IDLE -> DELAY on key_state 0->1 (raises press event); DELAY -> REPEAT after REP_DELAY cycles if repeat_en (raises repeat event); REPEAT raises a repeat event every REP_PERIOD cycles; any state -> IDLE on key_state 1->0 or repeat_en low. Timer restarts on every transition.
- Pending flag per key stores one event (id implicit, repeat bit stored). Event arriving while flag is set and not being cleared that cycle is dropped and sets evt_drop. Set and handshake-clear of the same key in the same cycle: new event retained.
- Arbiter: round-robin over pending flags starting at pointer; pointer resets to 0 and becomes (granted id + 1) mod NKEYS on each handshake.
- Output register: evt_valid, evt_id, evt_repeat stable while evt_valid && !evt_ready. Handshake clears that key's pending flag.

## Timing
- Reset values: evt_valid 0, evt_id 0, evt_repeat 0, key_state 0, evt_drop 0; all counters, FSMs IDLE, pending flags 0, pointer 0.
- key_state rises DEB_CYCLES+2 cycles after a clean raw press edge (2 sync + debounce).
- Pending set on the edge after key_state rises; evt_valid rises the following edge if output empty: press-to-valid = DEB_CYCLES+4 cycles.
- After a handshake, next event may be presented on the next edge (one bubble allowed, zero required? no: exactly one cycle gap), sustained throughput one event per 2 cycles.
- Glitch shorter than DEB_CYCLES: no key_state change, no event.
- Key held through rst: press event generated after deassertion, latency as above.
- rst mid-transfer: event discarded, evt_valid 0 on the edge rst is sampled.

## Structure
- Package key_evt_pkg: repeat FSM state encoding (IDLE, DELAY, REPEAT), counter-width helper constant/function.
- Sub-module key_channel: sync, debounce, repeat FSM, emits event pulse + repeat bit; key_event_arbiter instantiates NKEYS of them plus pending flags, round-robin and output register.

## Test plan (DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8, NKEYS=4, evt_ready=1 unless stated)
- key_in[1] pressed (driven 0) for 3 cycles then released -> no event, key_state stays 0.
- key_in[2] pressed and held, repeat_en=0 -> one event id=2 repeat=0 exactly 8 cycles after press; none further.
- key_in[0] held 60 cycles, repeat_en[0]=1 -> press event, repeat events at +20, +28, +36, ... stop within one cycle of key_state falling.
- keys 0,1,3 pressed same cycle -> events id 0,1,3 in order; then key 0 and 3 again together with pointer=0 after wrap -> order 0,3.
- evt_ready=0 for 50 cycles with key 1 repeating -> evt_id=1 held stable, evt_drop=1, exactly one subsequent pending event delivered on ready.
- rst asserted while evt_valid=1 -> evt_valid=0 next edge, evt_drop=0, pointer 0, no stale event after release.

Source files
------------

// File: rtl/key_event_arbiter_pkg.sv
// key_evt_pkg: repeat-FSM encoding and counter sizing shared by the key event path
package key_evt_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/key_event_arbiter_if.sv
// key_event_arbiter_if: valid/ready key event port
interface key_event_arbiter_if #(parameter int NKEYS = 4);
  logic evt_valid;
  logic evt_ready;
  logic evt_repeat;
  logic [$clog2(NKEYS)-1:0] evt_id;
  modport master(output evt_valid, evt_id, evt_repeat, input evt_ready);
  modport slave(input evt_valid, evt_id, evt_repeat, output evt_ready);
endinterface

// File: rtl/key_event_arbiter_channel.sv
// key_channel: one key's synchroniser, debouncer and auto-repeat FSM, emitting single-cycle event pulses
module key_channel
  import key_evt_pkg::*;
#(
  parameter int DEB_CYCLES     = 500000,
  parameter int REP_DELAY      = 25000000,
  parameter int REP_PERIOD     = 5000000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  input  logic repeat_en,
  output logic key_state,
  output logic evt,
  output logic evt_repeat
);
  localparam int DW = cnt_w(DEB_CYCLES);
  localparam int TW = cnt_w(REP_DELAY > REP_PERIOD ? REP_DELAY : REP_PERIOD);
  logic [1:0] sync;
  logic [DW-1:0] deb_cnt;
  logic [TW-1:0] tmr, tmr_n;
  logic ks_d;
  rep_state_t st, st_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= '0;
      deb_cnt   <= '0;
      key_state <= 1'b0;
      ks_d      <= 1'b0;
      st        <= IDLE;
      tmr       <= '0;
    end else begin
      sync <= {sync[0], (KEY_ACTIVE_LOW != 0) ? ~key_in : key_in};
      ks_d <= key_state;
      if (sync[1] == key_state) deb_cnt <= '0;
      else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
        deb_cnt   <= '0;
        key_state <= ~key_state;
      end else deb_cnt <= deb_cnt + 1'b1;
      st  <= st_n;
      tmr <= tmr_n;
    end
  end
  // A release or a dropped enable aborts repeating; only a fresh press re-arms
  always_comb begin
    st_n       = st;
    evt        = 1'b0;
    evt_repeat = 1'b0;
    if (st == IDLE) begin
      if (key_state && !ks_d) begin
        st_n = DELAY;
        evt  = 1'b1;
      end
    end else if (!key_state || !repeat_en) st_n = IDLE;
    else if (tmr == TW'((st == DELAY ? REP_DELAY : REP_PERIOD) - 1)) begin
      st_n       = REPEAT;
      evt        = 1'b1;
      evt_repeat = 1'b1;
    end
    tmr_n = (st_n != st || evt || st == IDLE) ? '0 : tmr + 1'b1;
  end
endmodule

// File: rtl/key_event_arbiter.sv
// key_event_arbiter: per-key event channels serialised onto one valid/ready port by a round-robin arbiter
module key_event_arbiter
  import key_evt_pkg::*;
#(
  parameter int NKEYS          = 4,
  parameter int DEB_CYCLES     = 500000,
  parameter int REP_DELAY      = 25000000,
  parameter int REP_PERIOD     = 5000000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NKEYS-1:0]         key_in,
  input  logic [NKEYS-1:0]         repeat_en,
  output logic [NKEYS-1:0]         key_state,
  output logic                     evt_drop,
  key_event_arbiter_if.master      evt
);
  localparam int IW = cnt_w(NKEYS);
  logic [NKEYS-1:0] ev, ev_rep, pend, prep, clr, take;
  logic [IW-1:0] ptr, gnt, idx;
  logic any, hs;
  for (genvar g = 0; g < NKEYS; g++) begin : g_ch
    key_channel #(
      .DEB_CYCLES(DEB_CYCLES),
      .REP_DELAY(REP_DELAY),
      .REP_PERIOD(REP_PERIOD),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .key_in(key_in[g]),
      .repeat_en(repeat_en[g]),
      .key_state(key_state[g]),
      .evt(ev[g]),
      .evt_repeat(ev_rep[g])
    );
  end
  assign hs   = evt.evt_valid && evt.evt_ready;
  assign clr  = NKEYS'(hs) << evt.evt_id;
  assign take = ev & (~pend | clr);
  // Scan from the highest offset down so the first pending key after ptr wins
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % NKEYS);
      if (pend[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end
  // A key's pending flag stays set while its event sits in the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      pend           <= '0;
      prep           <= '0;
      ptr            <= '0;
      evt_drop       <= 1'b0;
      evt.evt_valid  <= 1'b0;
      evt.evt_id     <= '0;
      evt.evt_repeat <= 1'b0;
    end else begin
      pend     <= ev | (pend & ~clr);
      prep     <= (take & ev_rep) | (~take & prep);
      evt_drop <= evt_drop || (|(ev & pend & ~clr));
      if (hs) begin
        evt.evt_valid <= 1'b0;
        ptr           <= (evt.evt_id == IW'(NKEYS - 1)) ? '0 : evt.evt_id + 1'b1;
      end else if (!evt.evt_valid && any) begin
        evt.evt_valid  <= 1'b1;
        evt.evt_id     <= gnt;
        evt.evt_repeat <= prep[gnt];
      end
    end
  end
endmodule

// File: tb/tb_key_event_arbiter.sv
// tb_key_event_arbiter: directed and random key stimulus checked against a behavioural event model
module tb_key_event_arbiter;
  localparam int N = 4, DEB = 4, RD = 20, RP = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] key_in = '1, repeat_en = '0, key_state;
  logic evt_drop;
  int n_vec = 0, n_bad = 0, hs_cnt = 0, base;
  int got[$];
  int exp_ord[5] = '{0, 1, 3, 0, 3};
  bit [N-1:0] dly[2];
  bit win[N][DEB];
  bit [N-1:0] m_ks, m_ks_last, m_active, m_pend, m_prep;
  int m_age[N];
  bit m_ov, m_orep, m_drop;
  int m_oid, m_ptr;

  key_event_arbiter_if #(.NKEYS(N)) bus ();
  key_event_arbiter #(
    .NKEYS(N), .DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_PERIOD(RP), .KEY_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .repeat_en(repeat_en),
    .key_state(key_state), .evt_drop(evt_drop), .evt(bus.master)
  );
  always #5 clk = ~clk;

  task automatic model_reset();
    dly[0] = '0; dly[1] = '0;
    for (int k = 0; k < N; k++) begin
      m_age[k] = 0;
      for (int j = 0; j < DEB; j++) win[k][j] = 1'b0;
    end
    m_ks = '0; m_ks_last = '0; m_active = '0; m_pend = '0; m_prep = '0;
    m_ov = 0; m_orep = 0; m_drop = 0; m_oid = 0; m_ptr = 0;
  endtask

  // Spec-level model: press on a debounced rise, repeats at ages RD, RD+RP, ... while held and enabled
  task automatic model_edge();
    bit [N-1:0] ev, evr;
    bit hs, clr, diff;
    int gsel;
    bit grep;
    if (rst) begin
      model_reset();
      return;
    end
    ev = '0; evr = '0;
    for (int k = 0; k < N; k++) begin
      if (m_ks[k] && !m_ks_last[k]) begin
        ev[k] = 1; m_active[k] = 1; m_age[k] = 0;
      end else if (m_active[k]) begin
        if (!m_ks[k] || !repeat_en[k]) m_active[k] = 0;
        else begin
          m_age[k]++;
          if (m_age[k] >= RD && (m_age[k] - RD) % RP == 0) begin ev[k] = 1; evr[k] = 1; end
        end
      end
    end
    hs = m_ov && bus.evt_ready;
    gsel = -1;
    if (!m_ov)
      for (int i = 0; i < N; i++)
        if (gsel < 0 && m_pend[(m_ptr + i) % N]) gsel = (m_ptr + i) % N;
    grep = (gsel >= 0) ? m_prep[gsel] : 1'b0;
    for (int k = 0; k < N; k++) begin
      clr = hs && (m_oid == k);
      if (ev[k]) begin
        if (m_pend[k] && !clr) m_drop = 1;
        else m_prep[k] = evr[k];
        m_pend[k] = 1;
      end else if (clr) m_pend[k] = 0;
    end
    if (hs) begin
      m_ov = 0; m_ptr = (m_oid + 1) % N;
    end else if (gsel >= 0) begin
      m_ov = 1; m_oid = gsel; m_orep = grep;
    end
    m_ks_last = m_ks;
    for (int k = 0; k < N; k++) begin
      for (int j = DEB - 1; j > 0; j--) win[k][j] = win[k][j-1];
      win[k][0] = dly[1][k];
      diff = 1;
      for (int j = 0; j < DEB; j++) if (win[k][j] == m_ks[k]) diff = 0;
      if (diff) m_ks[k] = ~m_ks[k];
    end
    dly[1] = dly[0];
    dly[0] = ~key_in;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      if (bus.evt_valid === 1'b1 && bus.evt_ready) begin
        hs_cnt++;
        got.push_back(int'(bus.evt_id));
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("key_state", key_state, m_ks);
      chk("evt_valid", bus.evt_valid, m_ov);
      chk("evt_id", bus.evt_id, m_oid);
      chk("evt_repeat", bus.evt_repeat, m_orep);
      chk("evt_drop", evt_drop, m_drop);
    end
  endtask

  initial begin
    bus.evt_ready = 1'b1;
    model_reset();
    step(3);
    rst = 1'b0;
    step(2);
    key_in[1] = 1'b0; step(3); key_in[1] = 1'b1; step(10);
    chk("glitch_no_event", hs_cnt, 0);
    base = hs_cnt;
    key_in[2] = 1'b0;
    for (int i = 1; i <= 12; i++) begin step(1); chk("press_latency", bus.evt_valid, i == 8); end
    step(30);
    chk("press_once", hs_cnt - base, 1);
    key_in[2] = 1'b1; step(12);
    repeat_en[0] = 1'b1; base = hs_cnt;
    key_in[0] = 1'b0; step(60); key_in[0] = 1'b1; step(20);
    chk("repeat_count", hs_cnt - base, 6);
    repeat_en[0] = 1'b0;
    rst = 1'b1; step(1); rst = 1'b0; step(2);
    got.delete();
    key_in = 4'b0100; step(20); key_in = '1; step(15);
    key_in = 4'b0110; step(20); key_in = '1; step(15);
    chk("order_len", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("order_id", (i < got.size()) ? got[i] : -1, exp_ord[i]);
    repeat_en[1] = 1'b1; bus.evt_ready = 1'b0; base = hs_cnt;
    key_in[1] = 1'b0; step(50);
    chk("stall_drop", evt_drop, 1);
    chk("stall_id", bus.evt_id, 1);
    bus.evt_ready = 1'b1; key_in[1] = 1'b1; step(20);
    chk("stall_deliver", hs_cnt - base, 2);
    repeat_en[1] = 1'b0;
    bus.evt_ready = 1'b0; key_in[3] = 1'b0; step(10);
    chk("pre_rst_valid", bus.evt_valid, 1);
    rst = 1'b1; step(1);
    chk("rst_valid", bus.evt_valid, 0);
    chk("rst_drop", evt_drop, 0);
    rst = 1'b0; key_in = '1; bus.evt_ready = 1'b1; base = hs_cnt; step(20);
    chk("rst_no_stale", hs_cnt - base, 0);
    key_in[2] = 1'b0; step(5); rst = 1'b1; step(2); rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin step(1); chk("held_rst_latency", bus.evt_valid, i == 8); end
    key_in = '1; step(12);
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(11) == 0) key_in[k] = ~key_in[k];
        if ($urandom_range(40) == 0) repeat_en[k] = ~repeat_en[k];
      end
      bus.evt_ready = ($urandom_range(9) < 7);
      rst = ($urandom_range(299) == 0);
      step(1);
    end
    rst = 1'b0; step(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
